// File: rtl/sel_pkg.sv
// sel_pkg: shared types for the sel_arbiter merge point.
// Build option ARB_FIXED_PRIO_EN (see sel_arbiter.sv) does not change these types.
package sel_pkg;

    // Output register occupancy: IDLE = empty, HOLD = word presented downstream
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    // Grant encoding deliberately matches the downstream mux select (1=A, 0=B)
    typedef logic grant_t;

    localparam grant_t SEL_A = 1'b1;
    localparam grant_t SEL_B = 1'b0;

endpackage

// File: rtl/sel_arbiter_rr_pick.sv
// rr_pick: combinational two-way pick between request A and request B.
// Ties go to the side that did not win last time, unless ARB_FIXED_PRIO_EN
// is defined, in which case A always wins and there is no history input.
module rr_pick
    import sel_pkg::*;
(
`ifndef ARB_FIXED_PRIO_EN
    input  grant_t last,
`endif
    input  logic   a_valid,
    input  logic   b_valid,
    output grant_t grant,
    output logic   any
);

    // Pick a winner; grant is only meaningful when any is high
    always_comb begin
        any   = a_valid || b_valid;
        grant = SEL_B;
        if (a_valid && b_valid) begin
`ifdef ARB_FIXED_PRIO_EN
            grant = SEL_A;
`else
            grant = (last == SEL_A) ? SEL_B : SEL_A;
`endif
        end else if (a_valid) begin
            grant = SEL_A;
        end
    end

endmodule

// File: rtl/sel_arbiter.sv
// sel_arbiter: merges two valid/ready streams into one registered output word
// plus the mux select s (1=A, 0=B) that chose it.
// Build option: define ARB_FIXED_PRIO_EN for fixed A-first priority (no history
// register); default build alternates ties round-robin, A first after reset.
module sel_arbiter
    import sel_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_valid,
    input  logic [W-1:0] a_data,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [W-1:0] b_data,
    output logic         b_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         o_ready,
    output logic         s
);

    arb_state_t   state_q, state_d;
    logic         o_valid_q, o_valid_d;
    logic [W-1:0] o_data_q, o_data_d;
    grant_t       s_q, s_d;
    grant_t       grant;
    logic         any;
    logic         load;
    logic         take;

`ifndef ARB_FIXED_PRIO_EN
    grant_t       last_q, last_d;
`endif

    rr_pick u_pick (
`ifndef ARB_FIXED_PRIO_EN
        .last    (last_q),
`endif
        .a_valid (a_valid),
        .b_valid (b_valid),
        .grant   (grant),
        .any     (any)
    );

    // The output slot can be refilled when empty or when its word retires this cycle
    always_comb begin
        load    = (state_q == IDLE) || o_ready;
        take    = !rst && load && any;
        a_ready = take && (grant == SEL_A);
        b_ready = take && (grant == SEL_B);
    end

    // Next-state: load the winner, drain to IDLE, or freeze under backpressure
    always_comb begin
        state_d   = state_q;
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        s_d       = s_q;
`ifndef ARB_FIXED_PRIO_EN
        last_d    = last_q;
`endif
        if (load) begin
            if (any) begin
                state_d   = HOLD;
                o_valid_d = 1'b1;
                o_data_d  = (grant == SEL_A) ? a_data : b_data;
                s_d       = grant;
`ifndef ARB_FIXED_PRIO_EN
                last_d    = grant;
`endif
            end else begin
                // Payload and select keep their old values; only o_valid drops
                state_d   = IDLE;
                o_valid_d = 1'b0;
            end
        end
    end

    // State and output registers; reset discards any held word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            s_q       <= SEL_B;
`ifndef ARB_FIXED_PRIO_EN
            last_q    <= SEL_B;
`endif
        end else begin
            state_q   <= state_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            s_q       <= s_d;
`ifndef ARB_FIXED_PRIO_EN
            last_q    <= last_d;
`endif
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign s       = s_q;

endmodule

// File: tb/tb_sel_arbiter.sv
// tb_sel_arbiter: directed steps for sel_arbiter with a word scoreboard.
// Expected words are queued as stimulus is driven; the monitor retires them on
// every o_valid && o_ready. Handles both builds via ARB_FIXED_PRIO_EN.
module tb_sel_arbiter;

    localparam int W = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         a_valid, b_valid, o_ready;
    logic [W-1:0] a_data, b_data;
    logic         a_ready, b_ready, o_valid, s;
    logic [W-1:0] o_data;

    int total = 0;
    int bad   = 0;

    // Expected output words: {data, s}
    logic [W:0] sb_q[$];

    sel_arbiter #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_ready (o_ready),
        .s       (s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then wait to mid-cycle
    task automatic step(input logic r, input logic av, input logic ad,
                        input logic bv, input logic bd, input logic ordy);
        @(posedge clk);
        #1;
        rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; o_ready = ordy;
        @(negedge clk);
    endtask

    // Scoreboard monitor: retire before recording, reset flushes held words
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else if (o_valid && o_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_word", 8'(o_valid), 8'd0);
            end else begin
                logic [W:0] e;
                e = sb_q.pop_front();
                chk("sb_data", 8'(o_data), 8'(e[W:1]));
                chk("sb_sel",  8'(s),      8'(e[0]));
            end
        end
    end

    initial begin
        logic exp_a;
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; o_ready = 1'b0;

        // Reset for two cycles with requests pending: no ready may escape
        step(1, 1, 1, 1, 1, 0);
        step(1, 1, 1, 1, 1, 0);
        chk("rst_o_valid", 8'(o_valid), 8'd0);
        chk("rst_o_data",  8'(o_data),  8'd0);
        chk("rst_s",       8'(s),       8'd0);
        chk("rst_a_ready", 8'(a_ready), 8'd0);
        chk("rst_b_ready", 8'(b_ready), 8'd0);

        // Both requesting every cycle: round-robin A,B,A,B (fixed build: A always)
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 1, 1, 0, 1);
`ifdef ARB_FIXED_PRIO_EN
            exp_a = 1'b1;
`else
            exp_a = (k % 2 == 0);
`endif
            chk("tie_a_ready", 8'(a_ready), 8'(exp_a));
            chk("tie_b_ready", 8'(b_ready), 8'(!exp_a));
            if (k > 0) chk("tie_o_valid", 8'(o_valid), 8'd1);
            sb_q.push_back(exp_a ? {1'b1, 1'b1} : {1'b0, 1'b0});
        end
        step(0, 0, 0, 0, 0, 1);
        chk("tie_last_valid", 8'(o_valid), 8'd1);

        // HOLD, o_ready=1, nothing new: output drains
        step(0, 0, 0, 0, 0, 1);
        chk("drain_o_valid", 8'(o_valid), 8'd0);

        // Only A: accepted immediately, visible one cycle later
        step(0, 1, 1, 0, 0, 1);
        chk("onlya_a_ready", 8'(a_ready), 8'd1);
        chk("onlya_b_ready", 8'(b_ready), 8'd0);
        chk("onlya_o_valid0", 8'(o_valid), 8'd0);
        sb_q.push_back({1'b1, 1'b1});

        // Word A presented; only B requests and is loaded back-to-back
        step(0, 0, 0, 1, 0, 1);
        chk("onlya_o_valid", 8'(o_valid), 8'd1);
        chk("onlya_o_data",  8'(o_data),  8'd1);
        chk("onlya_s",       8'(s),       8'd1);
        chk("onlyb_b_ready", 8'(b_ready), 8'd1);
        chk("onlyb_a_ready", 8'(a_ready), 8'd0);
        sb_q.push_back({1'b0, 1'b0});

        // Backpressure: B word frozen, no readies despite changing requests
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 1, 1, 1, 0);
            chk("bp_o_valid", 8'(o_valid), 8'd1);
            chk("bp_o_data",  8'(o_data),  8'd0);
            chk("bp_s",       8'(s),       8'd0);
            chk("bp_a_ready", 8'(a_ready), 8'd0);
            chk("bp_b_ready", 8'(b_ready), 8'd0);
        end

        // Release: B word retires, tie goes to A in the same edge
        step(0, 1, 1, 1, 1, 1);
        chk("rel_a_ready", 8'(a_ready), 8'd1);
        chk("rel_b_ready", 8'(b_ready), 8'd0);
        sb_q.push_back({1'b1, 1'b1});
        step(0, 0, 0, 0, 0, 1);
        chk("rel_o_s", 8'(s), 8'd1);
        step(0, 0, 0, 0, 0, 1);
        chk("rel_idle", 8'(o_valid), 8'd0);

        // Load A word and hold it, then reset mid-operation
        step(0, 1, 1, 0, 0, 0);
        chk("pre_rst_a_ready", 8'(a_ready), 8'd1);
        sb_q.push_back({1'b1, 1'b1});
        step(1, 1, 1, 1, 1, 0);
        chk("mid_rst_o_valid", 8'(o_valid), 8'd1);
        chk("mid_rst_a_ready", 8'(a_ready), 8'd0);
        chk("mid_rst_b_ready", 8'(b_ready), 8'd0);

        // After reset: word gone, first tie goes to A
        step(0, 1, 1, 1, 0, 1);
        chk("post_rst_o_valid", 8'(o_valid), 8'd0);
        chk("post_rst_o_data",  8'(o_data),  8'd0);
        chk("post_rst_s",       8'(s),       8'd0);
        chk("post_rst_a_ready", 8'(a_ready), 8'd1);
        chk("post_rst_b_ready", 8'(b_ready), 8'd0);
        sb_q.push_back({1'b1, 1'b1});
        step(0, 0, 0, 0, 0, 1);
        chk("post_rst_word", 8'(o_valid), 8'd1);
        step(0, 0, 0, 0, 0, 1);
        chk("final_idle", 8'(o_valid), 8'd0);

        chk("sb_empty", 8'(sb_q.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
